// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable registered or fall-through read port.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (ADDR_WIDTH < 1 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
            $error("sync_fifo_flags: illegal ADDR_WIDTH/AE_LEVEL/AF_LEVEL combination");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wr_en, rd_en;

    // Extra MSB on each pointer distinguishes a full FIFO from an empty one.
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign wr_en = wr & ~full;
    assign rd_en = rd & ~empty;

    assign count        = count_q;
    assign almost_full  = (int'(count_q) >= AF_LEVEL);
    assign almost_empty = (int'(count_q) <= AE_LEVEL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
        // A fresh error at the same edge as clr_err keeps the flag set.
        overflow_d  = (wr & full)  | (overflow_q  & ~clr_err);
        underflow_d = (rd & empty) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset; writes are simply blocked while rst is held.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_en) begin
                    dout_d = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule
